// File: rtl/tlp_framing_pkg.sv
// Shared constants and descriptor layout for the Gen3+ TLP framing checker.
package tlp_framing_pkg;

  localparam int MAX_TLP_PER_WORD = 4;
  localparam int LEN_W            = 5;
  localparam int TOKLEN_W         = 11;
  localparam int START_W          = 6;
  localparam int NBYTES           = 64;
  localparam int DESC_W           = START_W + LEN_W + TOKLEN_W + 1;

  localparam logic [2:0] GEN3 = 3'b011;
  localparam logic [2:0] GEN4 = 3'b100;
  localparam logic [2:0] GEN5 = 3'b101;

  // Packs as {start, len, tok_len, err}, 23 bits.
  typedef struct packed {
    logic [START_W-1:0]  start;
    logic [LEN_W-1:0]    len;
    logic [TOKLEN_W-1:0] tok_len;
    logic                err;
  } desc_t;

  function automatic logic is_gen3plus(input logic [2:0] g);
    return (g == GEN3) || (g == GEN4) || (g == GEN5);
  endfunction

endpackage

// File: rtl/tlp_framing_checker_desc_fifo.sv
// 4-write/1-read descriptor FIFO; a multi-push is accepted whole or not at all.
module desc_fifo
  import tlp_framing_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [2:0]                         push_n_i,
  input  desc_t [MAX_TLP_PER_WORD-1:0]       push_data_i,
  output logic                               push_ok_o,
  input  logic                               pop_i,
  output logic                               valid_o,
  output desc_t                              head_o
);

  localparam int AW = $clog2(DEPTH);

  desc_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, free;
  desc_t          last_q;
  logic           do_pop;

  // Room is judged before this cycle's pop so a pop never enables a push.
  assign free      = (AW+1)'(DEPTH) - count_q;
  assign push_ok_o = (push_n_i != 3'd0) && (free >= (AW+1)'(push_n_i));
  assign valid_o   = (count_q != '0);
  assign do_pop    = valid_o && pop_i;
  assign head_o    = valid_o ? mem_q[rd_ptr_q] : last_q;

  always_ff @(posedge clk) begin
    if (push_ok_o) begin
      for (int k = 0; k < MAX_TLP_PER_WORD; k++) begin
        if (3'(k) < push_n_i) mem_q[wr_ptr_q + AW'(k)] <= push_data_i[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push_ok_o) wr_ptr_q <= wr_ptr_q + AW'(push_n_i);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + (push_ok_o ? (AW+1)'(push_n_i) : '0) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/tlp_framing_checker.sv
// Pairs counted TLP lengths with STP token Length fields and queues descriptors.
module tlp_framing_checker
  import tlp_framing_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                pclk,
  input  logic                reset,
  input  logic [2:0]          gen,
  input  logic [511:0]        data_in,
  input  logic                wr,
  input  logic [63:0]         wr_valid,
  input  logic [63:0]         STP_IN,
  input  logic [63:0]         SDP_IN,
  input  logic [63:0]         END_IN,
  input  logic [79:0]         length,
  output logic                desc_valid,
  input  logic                desc_ready,
  output logic [START_W-1:0]  desc_start,
  output logic [LEN_W-1:0]    desc_len,
  output logic [TOKLEN_W-1:0] desc_tok_len,
  output logic                desc_err,
  output logic                overflow,
  output logic [15:0]         err_count,
  output logic [15:0]         drop_count
);

  desc_t [MAX_TLP_PER_WORD-1:0] ext_d, stage_q;
  logic [2:0]                   ext_n_d, stage_n_q;
  logic                         open;
  logic [START_W-1:0]           o_start;
  logic [TOKLEN_W-1:0]          o_tok;
  logic [LEN_W-1:0]             slot_len;

  logic                         push_ok;
  desc_t                        head;
  logic                         overflow_q, overflow_d;
  logic [15:0]                  err_count_q, err_count_d, drop_count_q, drop_count_d;
  logic [2:0]                   err_inc;
  logic [16:0]                  err_sum, drop_sum;

  logic unused_ok;
  assign unused_ok = ^{SDP_IN, length[79:20], data_in};

  // END is handled before STP at the same byte, so a close always has j > i.
  always_comb begin
    ext_d    = '0;
    ext_n_d  = 3'd0;
    open     = 1'b0;
    o_start  = '0;
    o_tok    = '0;
    slot_len = '0;
    if (wr && is_gen3plus(gen)) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (open && END_IN[i]) begin
          if (ext_n_d < 3'(MAX_TLP_PER_WORD)) begin
            slot_len                       = length[LEN_W*ext_n_d[1:0] +: LEN_W];
            ext_d[ext_n_d[1:0]].start      = o_start;
            ext_d[ext_n_d[1:0]].len        = slot_len;
            ext_d[ext_n_d[1:0]].tok_len    = o_tok;
            ext_d[ext_n_d[1:0]].err        = (o_tok != {6'b0, slot_len});
            ext_n_d                        = ext_n_d + 3'd1;
          end
          open = 1'b0;
        end
        if (STP_IN[i] && wr_valid[i]) begin
          open    = 1'b1;
          o_start = START_W'(i);
          // Byte 63 borrows byte 0 here, but such a TLP never closes in-word.
          o_tok   = {data_in[8*((i+1)%NBYTES) +: 7], data_in[8*i+4 +: 4]};
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      stage_q   <= '0;
      stage_n_q <= 3'd0;
    end else begin
      stage_q   <= ext_d;
      stage_n_q <= ext_n_d;
    end
  end

  desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (pclk),
    .rst         (reset),
    .push_n_i    (stage_n_q),
    .push_data_i (stage_q),
    .push_ok_o   (push_ok),
    .pop_i       (desc_ready),
    .valid_o     (desc_valid),
    .head_o      (head)
  );

  always_comb begin
    err_inc = 3'd0;
    for (int k = 0; k < MAX_TLP_PER_WORD; k++) begin
      if ((3'(k) < stage_n_q) && stage_q[k].err) err_inc = err_inc + 3'd1;
    end
    err_sum      = {1'b0, err_count_q} + 17'(err_inc);
    drop_sum     = {1'b0, drop_count_q} + 17'(stage_n_q);
    overflow_d   = overflow_q;
    err_count_d  = err_count_q;
    drop_count_d = drop_count_q;
    if (push_ok) begin
      err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end else if (stage_n_q != 3'd0) begin
      overflow_d   = 1'b1;
      drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      err_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      err_count_q  <= err_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign desc_start   = head.start;
  assign desc_len     = head.len;
  assign desc_tok_len = head.tok_len;
  assign desc_err     = head.err;
  assign overflow     = overflow_q;
  assign err_count    = err_count_q;
  assign drop_count   = drop_count_q;

endmodule

// File: doc/tlp_framing_checker.md
# tlp_framing_checker

Stage directly downstream of the per-cycle TLP length counter in the Gen3+ receive path. Each cycle it pairs the counted DW length of every TLP framed by STP/END in the 512-bit word with the 11-bit Length field of that TLP's STP token, and flags mismatches. It serializes up to four descriptors per cycle into a descriptor FIFO that downstream logic drains one per cycle under a valid/ready handshake.

## Interface
- DEPTH, 16: descriptor FIFO entries; power of two, ≥ 8.
- pclk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- gen  in  3  link generation; only 3'b011/100/101 produce descriptors.
- data_in  in  512  byte i = data_in[8i+7:8i].
- wr  in  1  word valid.
- wr_valid  in  64  per-byte valid.
- STP_IN / SDP_IN / END_IN  in  64 each  per-byte framing markers; SDP_IN is ignored.
- length  in  80  slot k = length[5k+4:5k], counted DWs of k-th completed TLP; slots 0..3 meaningful.
- desc_valid  out  1  FIFO non-empty.
- desc_ready  in  1  consumer accepts head entry.
- desc_start  out  6  byte index of the STP.
- desc_len  out  5  counted length from slot.
- desc_tok_len  out  11  token Length field.
- desc_err  out  1  desc_tok_len != {6'b0, desc_len}.
- overflow  out  1  sticky; cleared only by reset.
- err_count  out  16  saturating count of err descriptors written.
- drop_count  out  16  saturating count of descriptors dropped on overflow.

## Operation
- Extraction (combinational on inputs, only when wr=1 and gen is Gen3/4/5):
  - Scan bytes 0→63. An STP at byte i with wr_valid[i]=1 opens a TLP; a later STP before any END discards the open TLP, which gets no descriptor. The first END at byte j>i closes it.
  - Closed TLPs are numbered k=0,1,2,… in order of closure; only k≤3 are kept, later ones are ignored and not counted as drops.
  - desc k: start=i, len=length slot k, tok_len={byte(i+1)[6:0], byte(i)[7:4]}. STP at byte 63 cannot close in-word and yields no descriptor.
- Stage register: holds up to 4 descriptors plus count n (0..4), loaded every cycle. When wr=0 or gen is not Gen3+, n=0.
- FIFO write: if n>0 and free entries ≥ n, all n are written in k order. Otherwise none are written, overflow is set, and drop_count += n. Free entries are computed before this cycle's pop.
- FIFO read: the head is presented on the desc_* outputs and is popped when desc_valid && desc_ready.
- err_count increments by the number of written descriptors with err=1 and saturates at 16'hFFFF. drop_count also saturates.

## Timing
- Reset drives all of the following to 0: desc_valid, desc_start, desc_len, desc_tok_len, desc_err, overflow, err_count, drop_count. It also empties the FIFO and clears the stage register. Reset mid-operation discards in-flight descriptors.
- Latency:
  - Inputs sampled at edge N are loaded into the stage register at edge N.
  - They are written into the FIFO at edge N+1.
  - desc_valid is high after edge N+1 if the FIFO was empty and not blocked.
- Handshake:
  - desc_* outputs are stable while desc_valid=1 and desc_ready=0.
  - desc_ready may be high while desc_valid=0; this has no effect.
- Full: a write of n entries with exactly n free entries succeeds. A pop in the same cycle does not create room for that cycle's write.
- Empty: desc_valid=0, and desc_* hold their last values.
- Pointer wrap: log2(DEPTH)-bit pointers plus a (log2(DEPTH)+1)-bit occupancy count.

## Structure
- Shared package/header tlp_framing_pkg holds these constants:
  - MAX_TLP_PER_WORD=4, LEN_W=5, TOKLEN_W=11, START_W=6.
  - Descriptor packing order {start, len, tok_len, err}, 23 bits.
  - Gen3/4/5 encodings.
- Sub-module desc_fifo: 4-write/1-read synchronous FIFO with a DEPTH parameter and all-or-nothing multi-push.
- The top level contains extraction, the stage register and the counters.

## Test plan
- Single TLP: gen=3, STP@0 with bytes0/1 = 8'h30/8'h00 (tok_len=3), END@11, length slot0=3 → one descriptor {start 0, len 3, tok_len 3, err 0} with desc_valid 2 edges after the input; err_count=0.
- Mismatch: same word, slot0=2 → desc_err=1, err_count=1.
- Four TLPs at STP 0/16/32/48 with desc_ready=1 → four descriptors popped on consecutive cycles in start order 0,16,32,48.
- Overflow: DEPTH=16, desc_ready=0:
  - Four full 4-TLP words fill the FIFO and are accepted.
  - A fifth word is dropped: overflow=1, drop_count=4, FIFO count stays at 16.
- Orphan and gen gating:
  - STP@0, STP@8, END@20 → one descriptor with start 8.
  - The same word with gen=2 → no descriptor.
- Reset with 5 entries queued → next cycle desc_valid=0, and overflow, err_count and drop_count are all 0.
